// File: rtl/nn_mem_pkg.sv
// Shared constants for the NN BRAM loaders and writers: FSM encoding, default geometry
// and the layer base addresses in the shared BRAM.
package nn_mem_pkg;

    localparam int unsigned DefaultW           = 8;
    localparam int unsigned DefaultAddrWidth   = 18;
    localparam int unsigned DefaultReadLatency = 2;

    // Region where layer results are parked for the next layer's loader.
    localparam int unsigned LayerOutBase = 147504;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StWrite  = 2'b01,
        StVerify = 2'b10,
        StDone   = 2'b11
    } state_e;

endpackage

// File: rtl/bram_vector_writer_if.sv
// BRAM port bundle: the writer drives the strobes, address and write data; the BRAM
// returns read data.
interface bram_vector_writer_if
    import nn_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
    parameter int unsigned W          = DefaultW
);
    logic                  en;
    logic                  wen;
    logic                  ren;
    logic [ADDR_WIDTH-1:0] addr;
    logic [W-1:0]          din;
    logic [W-1:0]          dout;

    modport master (output en, wen, ren, addr, din, input dout);
    modport slave  (input en, wen, ren, addr, din, output dout);
endinterface

// File: rtl/bram_verify_pipe.sv
// Read-back checker: delays the expected word alongside the BRAM read latency and emits
// a one-cycle mismatch pulse when the returned word differs. READ_LATENCY must be >= 1.
module bram_verify_pipe
    import nn_mem_pkg::*;
#(
    parameter int unsigned W            = DefaultW,
    parameter int unsigned READ_LATENCY = DefaultReadLatency
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue,
    input  logic [W-1:0] expected,
    input  logic [W-1:0] dout,
    output logic         mismatch
);
    logic [READ_LATENCY-1:0]        valid_q;
    logic [READ_LATENCY-1:0][W-1:0] exp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            exp_q    <= '0;
            mismatch <= 1'b0;
        end else begin
            valid_q[0] <= issue;
            exp_q[0]   <= expected;
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                exp_q[i]   <= exp_q[i-1];
            end
            // Last stage lines up with the BRAM returning the word for this read.
            mismatch <= valid_q[READ_LATENCY-1] && (dout != exp_q[READ_LATENCY-1]);
        end
    end
endmodule

// File: rtl/bram_vector_writer.sv
// Snapshots a flat word vector on start and writes it to consecutive BRAM addresses.
// Define BRAM_WRITER_VERIFY_EN to re-read the region afterwards and flag mismatches.
module bram_vector_writer
    import nn_mem_pkg::*;
#(
    parameter int unsigned           IN_SIZE      = 1,
    parameter int unsigned           OUT_SIZE     = 8,
    parameter int unsigned           W            = DefaultW,
    parameter int unsigned           TOTAL_WORDS  = IN_SIZE * OUT_SIZE,
    parameter int unsigned           ADDR_WIDTH   = DefaultAddrWidth,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(LayerOutBase),
    parameter int unsigned           READ_LATENCY = DefaultReadLatency
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [TOTAL_WORDS*W-1:0] data_in,
    bram_vector_writer_if.master     bram,
    output logic                     busy,
    output logic                     done,
    output logic                     verify_err
);
    localparam int unsigned     CntW     = ADDR_WIDTH + 1;
    localparam int unsigned     VecW     = TOTAL_WORDS * W;
    localparam logic [CntW-1:0] LastWord = CntW'(TOTAL_WORDS - 1);

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [VecW-1:0]         shadow_q, shadow_d, shadow_rot;
    logic                    en_q, en_d, wen_q, wen_d, ren_q, ren_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [W-1:0]            din_q, din_d;
    logic                    busy_q, busy_d, done_q, done_d, verr_q, verr_d;
    logic                    issue, mismatch;

    // The shadow rotates one word per access so the current word is always at the bottom;
    // after N rotations it is back in place for the read-back pass.
    assign shadow_rot = (shadow_q >> W) | (shadow_q << ((TOTAL_WORDS - 1) * W));

`ifdef BRAM_WRITER_VERIFY_EN
    localparam logic [CntW-1:0] NumWords    = CntW'(TOTAL_WORDS);
    localparam logic [CntW-1:0] LastCompare = CntW'(TOTAL_WORDS + READ_LATENCY - 1);

    bram_verify_pipe #(
        .W            (W),
        .READ_LATENCY (READ_LATENCY)
    ) u_verify_pipe (
        .clk      (clk),
        .rst      (rst),
        .issue    (issue),
        .expected (shadow_q[W-1:0]),
        .dout     (bram.dout),
        .mismatch (mismatch)
    );
`else
    logic unused_verify;
    assign mismatch      = 1'b0;
    assign unused_verify = ^{issue, bram.dout, READ_LATENCY[0]};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        en_d     = 1'b0;
        wen_d    = 1'b0;
        ren_d    = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        verr_d   = verr_q | mismatch;
        issue    = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                done_d = (state_q == StDone);
                if (start) begin
                    shadow_d = data_in;
                    cnt_d    = '0;
                    verr_d   = 1'b0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    state_d  = StWrite;
                end
            end
            StWrite: begin
                busy_d   = 1'b1;
                en_d     = 1'b1;
                wen_d    = 1'b1;
                addr_d   = BASE_ADDR + cnt_q[ADDR_WIDTH-1:0];
                din_d    = shadow_q[W-1:0];
                shadow_d = shadow_rot;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastWord) begin
                    cnt_d = '0;
`ifdef BRAM_WRITER_VERIFY_EN
                    state_d = StVerify;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef BRAM_WRITER_VERIFY_EN
            StVerify: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q < NumWords) begin
                    en_d     = 1'b1;
                    ren_d    = 1'b1;
                    addr_d   = BASE_ADDR + cnt_q[ADDR_WIDTH-1:0];
                    issue    = 1'b1;
                    shadow_d = shadow_rot;
                end
                // Stay until the compare for the last read has been registered.
                if (cnt_q == LastCompare) begin
                    state_d = StDone;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
            en_q     <= 1'b0;
            wen_q    <= 1'b0;
            ren_q    <= 1'b0;
            addr_q   <= BASE_ADDR;
            din_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            verr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            en_q     <= en_d;
            wen_q    <= wen_d;
            ren_q    <= ren_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            verr_q   <= verr_d;
        end
    end

    assign bram.en    = en_q;
    assign bram.wen   = wen_q;
    assign bram.ren   = ren_q;
    assign bram.addr  = addr_q;
    assign bram.din   = din_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign verify_err = verr_q;
endmodule

// File: tb/tb_bram_vector_writer.sv
// Bench for bram_vector_writer: BRAM model, cycle-level timing model and directed
// scenarios. Builds with or without BRAM_WRITER_VERIFY_EN.
module tb_bram_vector_writer;
    localparam int unsigned     N    = 8;
    localparam int unsigned     W    = 8;
    localparam int unsigned     AW   = 18;
    localparam int unsigned     RL   = 2;
    localparam logic [AW-1:0]   BASE = 18'd147504;
`ifdef BRAM_WRITER_VERIFY_EN
    localparam bit VerifyOn = 1'b1;
`else
    localparam bit VerifyOn = 1'b0;
`endif
    // Cycles from the start edge to done: N+1 plain, 2N+RL+1 with read-back.
    localparam int TDone   = VerifyOn ? (2 * N + RL + 1) : (N + 1);
    localparam int HandLat = VerifyOn ? 19 : 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [N*W-1:0]   data_in;
    logic             busy, done, verify_err;

    bram_vector_writer_if #(.ADDR_WIDTH(AW), .W(W)) bram ();

    bram_vector_writer #(
        .IN_SIZE      (1),
        .OUT_SIZE     (8),
        .W            (W),
        .TOTAL_WORDS  (N),
        .ADDR_WIDTH   (AW),
        .BASE_ADDR    (BASE),
        .READ_LATENCY (RL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .bram       (bram),
        .busy       (busy),
        .done       (done),
        .verify_err (verify_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // BRAM model: one registered read stage, so data for a read issued at edge E is on
    // dout before edge E+RL where the writer compares it.
    logic [W-1:0] mem [0:15];
    logic [W-1:0] rd_q     = '0;
    int           n_writes = 0;
    bit           corrupt  = 1'b0;

    always @(posedge clk) begin
        if (bram.en && bram.wen && ((bram.addr - BASE) < 18'd16)) begin
            mem[4'(bram.addr - BASE)] <= (corrupt && bram.addr == 18'd147507) ? '0 : bram.din;
            n_writes <= n_writes + 1;
        end
        if (bram.en && bram.ren) rd_q <= mem[4'(bram.addr - BASE)];
    end
    assign bram.dout = rd_q;

    // Timing model: t counts edges since the accepted start edge.
    int             edges   = 0;
    int             t       = 0;
    bit             active  = 1'b0;
    bit             exp_err = 1'b0;
    logic [N*W-1:0] snap    = '0;

    task automatic check_outputs();
        logic [AW-1:0] a;
        if (!active) begin
            chk("idle en", bram.en, 1'b0);
            chk("idle wen", bram.wen, 1'b0);
            chk("idle ren", bram.ren, 1'b0);
            chk("idle addr", bram.addr, BASE);
            chk("idle din", bram.din, '0);
            chk("idle busy", busy, 1'b0);
            chk("idle done", done, 1'b0);
            chk("idle verify_err", verify_err, 1'b0);
        end else if (t == 0) begin
            chk("accept busy", busy, 1'b1);
            chk("accept done", done, 1'b0);
            chk("accept en", bram.en, 1'b0);
            chk("accept verify_err", verify_err, 1'b0);
        end else if (t <= N) begin
            a = BASE + AW'(t - 1);
            chk("write en", bram.en, 1'b1);
            chk("write wen", bram.wen, 1'b1);
            chk("write ren", bram.ren, 1'b0);
            chk("write addr", bram.addr, a);
            chk("write din", bram.din, snap[(t-1)*W +: W]);
            chk("write busy", busy, 1'b1);
            chk("write done", done, 1'b0);
        end else if (VerifyOn && t <= 2 * N) begin
            a = BASE + AW'(t - N - 1);
            chk("read en", bram.en, 1'b1);
            chk("read wen", bram.wen, 1'b0);
            chk("read ren", bram.ren, 1'b1);
            chk("read addr", bram.addr, a);
            chk("read busy", busy, 1'b1);
            chk("read done", done, 1'b0);
        end else if (t < TDone) begin
            chk("drain en", bram.en, 1'b0);
            chk("drain busy", busy, 1'b1);
            chk("drain done", done, 1'b0);
        end else begin
            chk("done en", bram.en, 1'b0);
            chk("done wen", bram.wen, 1'b0);
            chk("done ren", bram.ren, 1'b0);
            chk("done busy", busy, 1'b0);
            chk("done done", done, 1'b1);
            chk("done verify_err", verify_err, exp_err);
        end
    endtask

    always begin
        @(posedge clk);
        edges++;
        if (rst) begin
            active = 1'b0;
        end else if (start && (!active || t >= TDone)) begin
            active  = 1'b1;
            t       = 0;
            snap    = data_in;
            exp_err = VerifyOn && corrupt && (snap[3*W +: W] != '0);
        end else if (active) begin
            t++;
        end
        #1;
        check_outputs();
    end

    task automatic wait_done(input string name, input int e0);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, " latency"}, edges - e0, HandLat);
    endtask

    // One transfer; data_in is trashed right after the start edge to prove the snapshot.
    task automatic xfer(input string name, input logic [63:0] d, input bit poke);
        int e0, w0;
        @(negedge clk);
        data_in = d;
        start   = 1'b1;
        w0      = n_writes;
        @(negedge clk);
        start   = 1'b0;
        data_in = '1;
        e0      = edges;
        if (poke) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(name, e0);
        chk({name, " writes"}, n_writes - w0, N);
        chk({name, " busy"}, busy, 1'b0);
    endtask

    initial begin
        int w0, seen, e0;
        rst     = 1'b1;
        start   = 1'b0;
        data_in = 64'h0807060504030201;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        xfer("basic", 64'h0807060504030201, 1'b1);
        chk("mem 147504", mem[0], 8'h01);
        chk("mem 147507", mem[3], 8'h04);
        chk("mem 147511", mem[7], 8'h08);
        chk("basic verify_err", verify_err, 1'b0);

        xfer("restart", {8{8'hAA}}, 1'b0);
        chk("mem 147504 restart", mem[0], 8'hAA);
        chk("mem 147509 restart", mem[5], 8'hAA);

        // Reset after the third write strobe has been presented.
        @(negedge clk);
        data_in = 64'h1122334455667788;
        start   = 1'b1;
        w0      = n_writes;
        @(negedge clk);
        start = 1'b0;
        seen  = 0;
        for (int i = 0; i < 50 && seen < 3; i++) begin
            @(negedge clk);
            if (bram.en && bram.wen) seen++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort en", bram.en, 1'b0);
        chk("abort addr", bram.addr, 18'd147504);
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        repeat (5) @(negedge clk);
        chk("abort writes", n_writes - w0, 3);
        chk("mem 147506 abort", mem[2], 8'h66);

        xfer("readback pass", 64'h0807060504030201, 1'b0);
        chk("pass verify_err", verify_err, 1'b0);

        corrupt = 1'b1;
        xfer("readback fail", 64'h0807060504030201, 1'b0);
        chk("fail verify_err", verify_err, VerifyOn);
        repeat (4) @(negedge clk);
        chk("fail verify_err held", verify_err, VerifyOn);
        corrupt = 1'b0;

        @(negedge clk);
        data_in = 64'h0807060504030201;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0    = edges;
        chk("verify_err cleared", verify_err, 1'b0);
        wait_done("final", e0);
        chk("final verify_err", verify_err, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/bram_vector_writer.md
# bram_vector_writer

Sequential BRAM writer, the store-side counterpart of the layer bias/weight loaders. On `start` it snapshots a flat vector of `TOTAL_WORDS` W-bit words and writes them one per cycle to consecutive BRAM addresses from `BASE_ADDR`, then raises `done`. It sits between a layer's output register and the shared BRAM port so layer results can be parked for the next layer's loader. An optional read-back check re-reads the written region and flags mismatches.

## Interface
- `IN_SIZE`, 1: rows of the stored block.
- `OUT_SIZE`, 8: columns of the stored block.
- `W`, 8: word width in bits; equals the BRAM data width.
- `TOTAL_WORDS`, `IN_SIZE*OUT_SIZE`: words per transfer, at least 1.
- `ADDR_WIDTH`, 18: BRAM address width.
- `BASE_ADDR`, 147504: first BRAM address written.
- `READ_LATENCY`, 2: BRAM read latency in cycles; used only by the read-back check.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle request; sampled only in IDLE or DONE.
- `data_in` input `TOTAL_WORDS*W`: vector to store; word k is `data_in[k*W +: W]`.
- `bram_en` output 1: BRAM port enable.
- `bram_wen` output 1: BRAM write enable.
- `bram_ren` output 1: BRAM read enable.
- `bram_addr` output `ADDR_WIDTH`: BRAM address.
- `bram_din` output W: BRAM write data.
- `bram_dout` input W: BRAM read data; ignored unless the read-back check is compiled in.
- `busy` output 1: high in WRITE and VERIFY.
- `done` output 1: level signal, high in DONE.
- `verify_err` output 1: sticky mismatch flag.

## Operation
- States are IDLE, WRITE, VERIFY and DONE. Every output is registered.
- Reset puts the block in IDLE and sets every output to 0, with `bram_addr` = `BASE_ADDR`.
- IDLE or DONE with `start` high:
  - Copy `data_in` into a shadow register. Later changes to `data_in` have no effect on the transfer in progress.
  - Clear the word counter and `verify_err`, then go to WRITE.
- WRITE, word k: drive `bram_en` = `bram_wen` = 1, `bram_addr` = `BASE_ADDR`+k and `bram_din` = shadow word k.
- After word `TOTAL_WORDS`-1:
  - Go to VERIFY if the check is compiled in.
  - Otherwise go to DONE with `bram_en` = `bram_wen` = 0.
- VERIFY, read k: drive `bram_en` = `bram_ren` = 1, `bram_wen` = 0 and `bram_addr` = `BASE_ADDR`+k.
  - `READ_LATENCY` cycles after read k is issued, compare `bram_dout` against shadow word k.
  - On any mismatch, set `verify_err`. It stays set until the next accepted `start` or `rst`.
  - Go to DONE only after the last compare.
- DONE: all BRAM strobes are 0 and `done` = 1. The block stays in DONE until `start` or `rst`.
- `start` is ignored in WRITE and VERIFY.
- `rst` has priority over everything. Reset during a transfer aborts it immediately, and no further BRAM strobes are issued.
- Address arithmetic is `ADDR_WIDTH` bits and wraps modulo 2^`ADDR_WIDTH`. The block neither detects nor flags wrap.
- Counters are `ADDR_WIDTH`+1 bits wide.

## Timing
- Let C0 be the edge that samples `start` and N be `TOTAL_WORDS`.
- The write of word k is presented during cycle C0+1+k.
- Without the check, `done` rises at C0+N+1. Total latency is N+1 cycles.
- With the check:
  - Read k is presented during C0+N+1+k.
  - The compare for word k happens at C0+N+1+k+`READ_LATENCY`.
  - `done` rises at C0+2N+`READ_LATENCY`+1.
  - `verify_err` is valid when `done` rises.
- `busy` and `done` are never high together.
- On `start` in DONE, `done` falls on the next edge and `busy` rises on the same edge.
- With N = 1, WRITE lasts exactly one cycle.

## Configuration
- Macro: `BRAM_WRITER_VERIFY_EN`.
- Defined: the VERIFY state, the compare pipeline and `verify_err` are built as described above.
- Undefined: VERIFY is not generated. `bram_ren` and `verify_err` are tied to 0, `bram_dout` is unused, and WRITE goes straight to DONE.
- Port list is identical in both builds.

## Structure
- The shared package `nn_mem_pkg` holds:
  - the state encoding localparams: IDLE=2'b00, WRITE=2'b01, VERIFY=2'b10, DONE=2'b11;
  - the default `W`, `ADDR_WIDTH` and `READ_LATENCY`;
  - the layer base-address constants.
- One sub-module, `bram_verify_pipe`, holds the `READ_LATENCY`-deep expected-word/valid delay line and the comparator, and outputs a mismatch pulse.
- `bram_verify_pipe` is instantiated only under `BRAM_WRITER_VERIFY_EN`.

## Test plan
All scenarios use N=8, W=8 and `BASE_ADDR`=147504.
- **Basic write:** `data_in` = 0x0807060504030201, pulse `start`.
  - Required: writes to 147504..147511 carry 0x01..0x08 on consecutive cycles.
  - Required: `done` high 9 cycles after the `start` edge; `busy` low afterwards.
- **Snapshot:** change `data_in` to all 0xFF one cycle after `start`.
  - Required: the written bytes are still 0x01..0x08.
- **Ignored start and restart:** pulse `start` during WRITE.
  - Required: no effect; exactly 8 writes.
  - Then pulse `start` in DONE with `data_in` = 0xAA repeated. Required: a second burst of 8 writes of 0xAA.
- **Reset mid-transfer:** assert `rst` after 3 writes.
  - Required: no further strobes; all outputs reset; `bram_addr` = 147504; IDLE.
- **Read-back pass (`BRAM_WRITER_VERIFY_EN`, BRAM model with latency 2):**
  - Required: 8 reads follow the writes; `done` at cycle 19 after `start`; `verify_err` = 0.
- **Read-back fail:** the BRAM model corrupts address 147507 to 0x00.
  - Required: `verify_err` = 1 at `done` and held until the next `start`.
